dk_ctrl: RTL and testbench
==========================

# dk_ctrl

Frame-synchronous behaviour controller for the Donkey Kong sprite. It owns the position (`curr_h`, `curr_v`) and sprite selection (`sprite_selec`) consumed by `dk_pos`, and sequences the character through idle, patrol walking, grab and barrel-throw animations. All updates occur on the VGA frame tick, so position and sprite stay stable for a whole frame of scan-out.

## Interface
- `START_H`, 150: reset/idle horizontal position (top-left of the sprite).
- `START_V`, 390: fixed vertical position.
- `H_MIN`, 100: left patrol bound.
- `H_MAX`, 200: right patrol bound. Constraint: `H_MIN < H_MAX` and `H_MAX + STEP ≤ 1023`.
- `STEP`, 2: pixels moved per frame tick while walking.
- `FRAMES_PER_SPRITE`, 4: frame ticks between walk-sprite toggles.
- `GRAB_FRAMES`, 8: frame ticks spent in GRAB.
- `THROW_FRAMES`, 8: frame ticks spent in THROW.
- `THROW_PERIOD`, 120: auto-throw interval in frame ticks. Used only with `DK_AUTO_THROW_EN`.
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  asynchronous reset, active-low.
- `frame_tick`  in  1  one-cycle pulse, once per frame, at the end of active video.
- `enable`  in  1  1 = patrol/throw, 0 = return to idle.
- `throw_req`  in  1  single-cycle request for a barrel throw.
- `throw_ack`  out  1  one-cycle pulse when a request is latched.
- `curr_h`  out  10  sprite x origin, unsigned.
- `curr_v`  out  10  sprite y origin, unsigned, always `START_V`.
- `sprite_selec`  out  2  0/1 = walk frames, 2 = grab, 3 = throw.
- `barrel_spawn`  out  1  one-cycle pulse on THROW entry.

## Operation
- States: IDLE, WALK_R, WALK_L, GRAB, THROW. A `last_dir` register remembers the walk direction.
- Every state transition and every position, sprite or counter update happens only on a cycle with `frame_tick=1`. The exceptions are `throw_ack`, `barrel_spawn` and the pending latch.
- IDLE: `sprite_selec=0`, position held. Tick with `enable=1` moves to WALK_R, or to WALK_L if `last_dir`=L.
- WALK_R: per tick `curr_h += STEP`.
  - If `curr_h + STEP ≥ H_MAX`: set `curr_h=H_MAX`, move to WALK_L.
- WALK_L: symmetric. If `curr_h ≤ H_MIN + STEP`: clamp to `H_MIN`, move to WALK_R.
- Walk animation: a tick counter wraps at `FRAMES_PER_SPRITE-1`; `sprite_selec` toggles 0↔1 on the wrap. The counter clears on entry to any walk state.
- Throw pending latch:
  - Set by `throw_req` when no throw is pending and state ∉ {GRAB, THROW}; `throw_ack` pulses the following cycle.
  - Requests arriving while pending, or during GRAB/THROW, are dropped with no ack.
- Walk tick with pending=1 moves to GRAB instead of moving: position held, `sprite_selec=2`, pending cleared.
- A `throw_req` on the same cycle as `frame_tick` is latched but not acted on until the next tick.
- GRAB: after `GRAB_FRAMES` ticks, move to THROW (`sprite_selec=3`); `barrel_spawn` pulses the cycle after the transition tick.
- THROW: after `THROW_FRAMES` ticks, return to `last_dir` walk state, or IDLE if `enable=0`.
- `enable=0` on a tick in a walk state moves to IDLE. GRAB/THROW always complete first. A pending request survives IDLE.

## Timing
- All outputs are registered. Reset values:
  - `curr_h=START_H`, `curr_v=START_V`, `sprite_selec=0`
  - `throw_ack=0`, `barrel_spawn=0`
  - state IDLE, `last_dir`=R, pending=0, all counters 0.
- Latency: position/sprite outputs change one clock after the `frame_tick` cycle.
- `throw_ack` and `barrel_spawn` are exactly one cycle wide.
- Reset assertion mid-sequence (including GRAB/THROW) aborts immediately to reset values with no `barrel_spawn`.
- 10-bit unsigned arithmetic. The parameter constraint guarantees no overflow or underflow.

## Configuration
- `DK_AUTO_THROW_EN` defined: an internal frame counter sets pending (as if `throw_req`, including `throw_ack`) every `THROW_PERIOD` ticks while `enable=1`. The counter resets on reset and while `enable=0`. `throw_req` remains functional.
- Undefined: throws come only from `throw_req`; counter logic is not built.

## Test plan
- Reset low then high, `enable=0`, 10 ticks -> `curr_h=150`, `curr_v=390`, `sprite_selec=0`, no pulses.
- `enable=1` from reset -> after 25 ticks `curr_h=200`, state WALK_L; next tick `curr_h=198`. `sprite_selec` toggles every 4 ticks.
- Walking left, continue to `H_MIN` -> `curr_h` clamps at 100, then increments to 102.
- `throw_req` at `curr_h=160` walking right -> `throw_ack` next cycle; next tick `sprite_selec=2` with `curr_h` held. After 8 ticks `sprite_selec=3` and one `barrel_spawn`. After 8 more ticks walking resumes at 162.
- Second `throw_req` during GRAB, and `throw_req` on a `frame_tick` cycle -> first gets no ack; second acks but the transition waits one extra tick.
- Reset pulse during THROW -> all outputs at reset values, no `barrel_spawn`. With `DK_AUTO_THROW_EN`, `THROW_PERIOD=10`: `throw_ack` every 10 ticks while walking.

Source files
------------

// File: rtl/dk_ctrl.sv
// dk_ctrl -- frame-synchronous behaviour controller for the Donkey Kong sprite.
//
// Owns the sprite origin (curr_h, curr_v) and the sprite selection index
// consumed by dk_pos. It moves the character through idle, left/right patrol,
// grab and barrel-throw animations. Position, sprite, state and counters only
// change on a frame_tick cycle, so they stay stable for a whole frame of scan-out.
// The only exceptions are the throw pending latch, throw_ack and barrel_spawn.
//
// Ports:
//   clk           in   pixel/system clock
//   reset         in   asynchronous reset, active-low
//   frame_tick    in   one-cycle pulse per frame (end of active video)
//   enable        in   1 = patrol/throw, 0 = return to idle
//   throw_req     in   single-cycle barrel-throw request
//   throw_ack     out  one-cycle pulse when a request is latched
//   curr_h        out  sprite x origin (10-bit unsigned)
//   curr_v        out  sprite y origin (constant START_V)
//   sprite_selec  out  0/1 walk frames, 2 grab, 3 throw
//   barrel_spawn  out  one-cycle pulse on THROW entry
//
// Optional feature macro: DK_AUTO_THROW_EN
//   When defined, a frame counter raises a throw request every THROW_PERIOD
//   ticks while enable=1. When undefined, that counter is not built.

module dk_ctrl #(
  parameter int START_H           = 150,
  parameter int START_V           = 390,
  parameter int H_MIN             = 100,
  parameter int H_MAX             = 200,
  parameter int STEP              = 2,
  parameter int FRAMES_PER_SPRITE = 4,
  parameter int GRAB_FRAMES       = 8,
  parameter int THROW_FRAMES      = 8,
  parameter int THROW_PERIOD      = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       throw_req,
  output logic       throw_ack,
  output logic [9:0] curr_h,
  output logic [9:0] curr_v,
  output logic [1:0] sprite_selec,
  output logic       barrel_spawn
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK_R = 3'd1,
    S_WALK_L = 3'd2,
    S_GRAB   = 3'd3,
    S_THROW  = 3'd4
  } state_e;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  state_e     state_q, state_d;
  logic       last_dir_q, last_dir_d;
  logic       pending_q, pending_d;
  logic [7:0] anim_cnt_q, anim_cnt_d;
  logic [7:0] phase_cnt_q, phase_cnt_d;
  logic [9:0] curr_h_q, curr_h_d;
  logic [9:0] curr_v_q;
  logic [1:0] sprite_q, sprite_d;
  logic       ack_q, ack_d;
  logic       spawn_q, spawn_d;

  // Step helpers: next position and turnaround flag for each direction.
  logic       r_turn_s, l_turn_s;
  logic [9:0] r_pos_s, l_pos_s;
  // Result of (re)entering the walk state indicated by last_dir.
  state_e     enter_state_s;
  logic [9:0] enter_h_s;
  logic       enter_dir_s;
  logic       req_src_s;
  logic       accept_s;
  logic       pend_clr_s;
  logic       auto_fire_s;

`ifdef DK_AUTO_THROW_EN
  logic [15:0] auto_cnt_q, auto_cnt_d;

  // Auto-throw period counter: counts ticks while enabled, fires on wrap.
  always_comb begin
    auto_cnt_d  = auto_cnt_q;
    auto_fire_s = 1'b0;
    if (!enable) begin
      auto_cnt_d = 16'd0;
    end else if (frame_tick) begin
      if (auto_cnt_q == 16'(THROW_PERIOD - 1)) begin
        auto_cnt_d  = 16'd0;
        auto_fire_s = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + 16'd1;
      end
    end else begin
      auto_cnt_d = auto_cnt_q;
    end
  end

  // Auto-throw counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      auto_cnt_q <= 16'd0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
    end
  end
`else
  assign auto_fire_s = 1'b0;
`endif

  assign req_src_s = throw_req | auto_fire_s;

  // Per-direction step results; the parameter constraint rules out wrap-around.
  always_comb begin
    r_turn_s = ((curr_h_q + 10'(STEP)) >= 10'(H_MAX));
    l_turn_s = (curr_h_q <= 10'(H_MIN + STEP));
    r_pos_s  = r_turn_s ? 10'(H_MAX) : (curr_h_q + 10'(STEP));
    l_pos_s  = l_turn_s ? 10'(H_MIN) : (curr_h_q - 10'(STEP));
  end

  // Entering a walk (from IDLE or THROW) takes a step straight away,
  // including a possible clamp/turnaround.
  always_comb begin
    enter_state_s = S_WALK_R;
    enter_h_s     = curr_h_q;
    enter_dir_s   = DIR_R;
    if (last_dir_q == DIR_L) begin
      enter_h_s     = l_pos_s;
      enter_state_s = l_turn_s ? S_WALK_R : S_WALK_L;
      enter_dir_s   = l_turn_s ? DIR_R : DIR_L;
    end else begin
      enter_h_s     = r_pos_s;
      enter_state_s = r_turn_s ? S_WALK_L : S_WALK_R;
      enter_dir_s   = r_turn_s ? DIR_L : DIR_R;
    end
  end

  // Next-state and datapath logic for the behaviour FSM.
  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    anim_cnt_d  = anim_cnt_q;
    phase_cnt_d = phase_cnt_q;
    curr_h_d    = curr_h_q;
    sprite_d    = sprite_q;
    spawn_d     = 1'b0;
    pend_clr_s  = 1'b0;

    if (frame_tick) begin
      case (state_q)
        S_IDLE: begin
          sprite_d = 2'd0;
          if (enable) begin
            state_d    = enter_state_s;
            curr_h_d   = enter_h_s;
            last_dir_d = enter_dir_s;
            anim_cnt_d = 8'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WALK_R, S_WALK_L: begin
          if (!enable) begin
            state_d  = S_IDLE;
            sprite_d = 2'd0;
          end else if (pending_q) begin
            // Stop and grab a barrel; position is held this tick.
            state_d     = S_GRAB;
            sprite_d    = 2'd2;
            phase_cnt_d = 8'd0;
            pend_clr_s  = 1'b1;
          end else if ((state_q == S_WALK_R) ? r_turn_s : l_turn_s) begin
            // Clamp at the patrol bound and turn around; sprite is kept.
            state_d    = (state_q == S_WALK_R) ? S_WALK_L : S_WALK_R;
            last_dir_d = (state_q == S_WALK_R) ? DIR_L : DIR_R;
            curr_h_d   = (state_q == S_WALK_R) ? r_pos_s : l_pos_s;
            anim_cnt_d = 8'd0;
          end else begin
            curr_h_d = (state_q == S_WALK_R) ? r_pos_s : l_pos_s;
            if (anim_cnt_q == 8'(FRAMES_PER_SPRITE - 1)) begin
              anim_cnt_d = 8'd0;
              sprite_d   = {1'b0, ~sprite_q[0]};
            end else begin
              anim_cnt_d = anim_cnt_q + 8'd1;
            end
          end
        end
        S_GRAB: begin
          if (phase_cnt_q == 8'(GRAB_FRAMES - 1)) begin
            state_d     = S_THROW;
            sprite_d    = 2'd3;
            phase_cnt_d = 8'd0;
            spawn_d     = 1'b1;
          end else begin
            phase_cnt_d = phase_cnt_q + 8'd1;
          end
        end
        S_THROW: begin
          if (phase_cnt_q == 8'(THROW_FRAMES - 1)) begin
            phase_cnt_d = 8'd0;
            sprite_d    = 2'd0;
            if (enable) begin
              state_d    = enter_state_s;
              curr_h_d   = enter_h_s;
              last_dir_d = enter_dir_s;
              anim_cnt_d = 8'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            phase_cnt_d = phase_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          sprite_d = 2'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Pending latch: requests are taken only when nothing is pending and the
  // character is not already grabbing/throwing; the ack follows one cycle later.
  always_comb begin
    accept_s = req_src_s && !pending_q && (state_q != S_GRAB) && (state_q != S_THROW);
    ack_d    = accept_s;
    if (accept_s) begin
      pending_d = 1'b1;
    end else if (pend_clr_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_dir_q  <= DIR_R;
      pending_q   <= 1'b0;
      anim_cnt_q  <= 8'd0;
      phase_cnt_q <= 8'd0;
      curr_h_q    <= 10'(START_H);
      curr_v_q    <= 10'(START_V);
      sprite_q    <= 2'd0;
      ack_q       <= 1'b0;
      spawn_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      pending_q   <= pending_d;
      anim_cnt_q  <= anim_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      curr_h_q    <= curr_h_d;
      curr_v_q    <= 10'(START_V);
      sprite_q    <= sprite_d;
      ack_q       <= ack_d;
      spawn_q     <= spawn_d;
    end
  end

  assign throw_ack    = ack_q;
  assign curr_h       = curr_h_q;
  assign curr_v       = curr_v_q;
  assign sprite_selec = sprite_q;
  assign barrel_spawn = spawn_q;

endmodule

// File: tb/tb_dk_ctrl.sv
// Directed self-checking bench for dk_ctrl (default build, no auto-throw).
module tb_dk_ctrl;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic       throw_req;
  logic       throw_ack;
  logic [9:0] curr_h;
  logic [9:0] curr_v;
  logic [1:0] sprite_selec;
  logic       barrel_spawn;

  int n_tests;
  int n_fail;
  int spawn_cnt;
  int ack_cnt;
  int spawn_base;

  dk_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .throw_req    (throw_req),
    .throw_ack    (throw_ack),
    .curr_h       (curr_h),
    .curr_v       (curr_v),
    .sprite_selec (sprite_selec),
    .barrel_spawn (barrel_spawn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (barrel_spawn) spawn_cnt = spawn_cnt + 1;
    if (throw_ack) ack_cnt = ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame tick; returns at the negedge after the sampling edge.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Off-tick request; returns in the cycle where the ack would be visible.
  task automatic req_off();
    @(negedge clk);
    throw_req = 1'b1;
    @(negedge clk);
    throw_req = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; spawn_cnt = 0; ack_cnt = 0;
    reset = 1'b0; frame_tick = 1'b0; enable = 1'b0; throw_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_h", 32'(curr_h), 32'd150);
    chk("rst_v", 32'(curr_v), 32'd390);
    chk("rst_sprite", 32'(sprite_selec), 32'd0);
    chk("rst_ack", 32'(throw_ack), 32'd0);
    chk("rst_spawn", 32'(barrel_spawn), 32'd0);
    reset = 1'b1;

    // Idle with enable low.
    ticks(10);
    chk("idle_h", 32'(curr_h), 32'd150);
    chk("idle_v", 32'(curr_v), 32'd390);
    chk("idle_sprite", 32'(sprite_selec), 32'd0);
    #1;
    chk("idle_pulses", 32'(spawn_cnt + ack_cnt), 32'd0);

    // Walk right and throw at h=160.
    enable = 1'b1;
    ticks(4);
    chk("walk_h_t4", 32'(curr_h), 32'd158);
    chk("walk_sprite_t4", 32'(sprite_selec), 32'd0);
    tick();
    chk("walk_h_t5", 32'(curr_h), 32'd160);
    chk("walk_sprite_t5", 32'(sprite_selec), 32'd1);
    req_off();
    chk("ack_pulse", 32'(throw_ack), 32'd1);
    @(negedge clk);
    chk("ack_width", 32'(throw_ack), 32'd0);
    tick();
    chk("grab_sprite", 32'(sprite_selec), 32'd2);
    chk("grab_h", 32'(curr_h), 32'd160);
    req_off();
    chk("grab_req_noack", 32'(throw_ack), 32'd0);
    @(negedge clk);
    chk("grab_req_noack2", 32'(throw_ack), 32'd0);
    ticks(7);
    chk("grab_hold_sprite", 32'(sprite_selec), 32'd2);
    chk("grab_no_spawn", 32'(barrel_spawn), 32'd0);
    tick();
    chk("throw_sprite", 32'(sprite_selec), 32'd3);
    chk("spawn_pulse", 32'(barrel_spawn), 32'd1);
    @(negedge clk);
    chk("spawn_width", 32'(barrel_spawn), 32'd0);
    ticks(7);
    chk("throw_hold_sprite", 32'(sprite_selec), 32'd3);
    chk("throw_hold_h", 32'(curr_h), 32'd160);
    tick();
    chk("resume_h", 32'(curr_h), 32'd162);
    chk("resume_sprite", 32'(sprite_selec), 32'd0);

    // Request coincident with a frame tick: latched, acted on next tick.
    @(negedge clk);
    frame_tick = 1'b1; throw_req = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; throw_req = 1'b0;
    chk("tickreq_ack", 32'(throw_ack), 32'd1);
    chk("tickreq_h", 32'(curr_h), 32'd164);
    chk("tickreq_sprite", 32'(sprite_selec), 32'd0);
    tick();
    chk("tickreq_grab", 32'(sprite_selec), 32'd2);
    chk("tickreq_grab_h", 32'(curr_h), 32'd164);
    ticks(8);
    chk("throw2_sprite", 32'(sprite_selec), 32'd3);
    ticks(2);
    #1;
    chk("ack_count", 32'(ack_cnt), 32'd2);
    chk("spawn_count", 32'(spawn_cnt), 32'd1 + 32'd1);

    // Reset in the middle of THROW.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_h", 32'(curr_h), 32'd150);
    chk("midrst_sprite", 32'(sprite_selec), 32'd0);
    chk("midrst_spawn", 32'(barrel_spawn), 32'd0);
    chk("midrst_ack", 32'(throw_ack), 32'd0);
    spawn_base = spawn_cnt;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ticks(12);
    #1;
    chk("midrst_nospawn", 32'(spawn_cnt), 32'(spawn_base));
    chk("midrst_idle_h", 32'(curr_h), 32'd150);

    // Full patrol: right bound then left bound.
    enable = 1'b1;
    ticks(25);
    chk("bound_r_h", 32'(curr_h), 32'd200);
    tick();
    chk("turn_l_h", 32'(curr_h), 32'd198);
    ticks(48);
    chk("near_l_h", 32'(curr_h), 32'd102);
    tick();
    chk("bound_l_h", 32'(curr_h), 32'd100);
    tick();
    chk("turn_r_h", 32'(curr_h), 32'd102);

    // Disable while walking: back to IDLE, position held.
    enable = 1'b0;
    tick();
    chk("dis_h", 32'(curr_h), 32'd102);
    chk("dis_sprite", 32'(sprite_selec), 32'd0);
    ticks(3);
    chk("dis_hold_h", 32'(curr_h), 32'd102);
    chk("dis_v", 32'(curr_v), 32'd390);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
